rally_sequencer: RTL and testbench



---
 rtl/rally_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_rally_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rally_sequencer.sv
// rally_sequencer: game-flow controller for the rally game.
// Sequences TITLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER) -> TITLE, drives the shared
// game_state bus, latches the difficulty, detects ball landings and keeps the score.
// Optional feature: define RALLY_DEUCE_EN to require a two-point lead to win (31 always wins).
`timescale 1ns/1ps

module rally_sequencer #(
  parameter int unsigned WIN_SCORE    = 15,
  parameter int unsigned GROUND_Y     = 220,
  parameter int unsigned NET_X        = 160,
  parameter int unsigned BALL_SIZE    = 32,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned OVER_FRAMES  = 300
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        mode_btn,
  input  logic [11:0] ball_pos_x,
  input  logic [11:0] ball_pos_y,
  output logic [1:0]  game_state,
  output logic        game_mode,
  output logic [4:0]  npc_score,
  output logic [4:0]  player_score,
  output logic        serve_side,
  output logic        last_point,
  output logic        game_over,
  output logic        winner
);

  typedef enum logic [2:0] {StTitle, StServe, StPlay, StPoint, StOver} state_e;

  // Last frame index of each timed phase; the transition fires on the edge sampling that tick.
  localparam logic [8:0]  ServeLast = 9'(SERVE_FRAMES - 1);
  localparam logic [8:0]  PointLast = 9'(POINT_FRAMES - 1);
  localparam logic [8:0]  OverLast  = 9'(OVER_FRAMES - 1);
  localparam logic [12:0] GroundY   = 13'(GROUND_Y);
  localparam logic [12:0] NetX      = 13'(NET_X);
  localparam logic [12:0] BallSize  = 13'(BALL_SIZE);
  localparam logic [12:0] BallHalf  = 13'(BALL_SIZE / 2);
  localparam logic [4:0]  WinScore  = 5'(WIN_SCORE);
  localparam logic [4:0]  ScoreMax  = 5'd31;

  state_e      state;
  logic        start_q;
  logic        mode_q;
  logic [8:0]  frame_cnt;

  logic        start_rise;
  logic        mode_rise;
  logic [12:0] ball_bottom;
  logic [12:0] ball_centre;
  logic        landed;
  logic        player_scores;
  logic [4:0]  npc_inc;
  logic [4:0]  player_inc;
  logic [4:0]  scorer_score;
  logic [4:0]  opp_score;
  logic        win;

  // Edge detection, landing geometry and win evaluation.
  always_comb begin
    start_rise    = start_btn & ~start_q;
    mode_rise     = mode_btn & ~mode_q;
    // 13-bit sums so a ball near the bottom of the 12-bit range cannot wrap.
    ball_bottom   = {1'b0, ball_pos_y} + BallSize;
    ball_centre   = {1'b0, ball_pos_x} + BallHalf;
    landed        = ball_bottom >= GroundY;
    // Ball landing on the NPC half is a point for the player.
    player_scores = ball_centre < NetX;
    npc_inc       = (npc_score == ScoreMax) ? ScoreMax : npc_score + 5'd1;
    player_inc    = (player_score == ScoreMax) ? ScoreMax : player_score + 5'd1;
    // last_point names the scorer of the point being frozen in POINT.
    scorer_score  = last_point ? player_score : npc_score;
    opp_score     = last_point ? npc_score : player_score;
`ifdef RALLY_DEUCE_EN
    win = (scorer_score == ScoreMax) ||
          ((scorer_score >= WinScore) && (scorer_score >= opp_score) &&
           ((scorer_score - opp_score) >= 5'd2));
`else
    win = (scorer_score == WinScore);
`endif
  end

  // Game FSM with registered outputs, button edge registers and the frame counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= StTitle;
      start_q      <= 1'b0;
      mode_q       <= 1'b0;
      frame_cnt    <= 9'd0;
      game_state   <= 2'd0;
      game_mode    <= 1'b0;
      npc_score    <= 5'd0;
      player_score <= 5'd0;
      serve_side   <= 1'b1;
      last_point   <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 1'b0;
    end else begin
      start_q <= start_btn;
      mode_q  <= mode_btn;
      case (state)
        StTitle: begin
          if (mode_rise) begin
            game_mode <= ~game_mode;
          end
          // A start rise wins over a simultaneous tick: the tick is not counted.
          if (start_rise) begin
            state        <= StServe;
            game_state   <= 2'd1;
            npc_score    <= 5'd0;
            player_score <= 5'd0;
            serve_side   <= 1'b1;
            frame_cnt    <= 9'd0;
          end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 9'd1;
          end
        end
        StServe: begin
          if (frame_tick) begin
            if (frame_cnt == ServeLast) begin
              state      <= StPlay;
              game_state <= 2'd2;
              frame_cnt  <= 9'd0;
            end else begin
              frame_cnt <= frame_cnt + 9'd1;
            end
          end
        end
        StPlay: begin
          if (frame_tick && landed) begin
            if (player_scores) begin
              player_score <= player_inc;
              last_point   <= 1'b1;
              serve_side   <= 1'b1;
            end else begin
              npc_score  <= npc_inc;
              last_point <= 1'b0;
              serve_side <= 1'b0;
            end
            state      <= StPoint;
            game_state <= 2'd3;
            frame_cnt  <= 9'd0;
          end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 9'd1;
          end
        end
        StPoint: begin
          if (frame_tick) begin
            if (frame_cnt == PointLast) begin
              frame_cnt <= 9'd0;
              if (win) begin
                state      <= StOver;
                game_state <= 2'd0;
                game_over  <= 1'b1;
                winner     <= last_point;
              end else begin
                state      <= StServe;
                game_state <= 2'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + 9'd1;
            end
          end
        end
        StOver: begin
          // Timeout and start rise may coincide; either way a single move to TITLE.
          if (start_rise || (frame_tick && (frame_cnt == OverLast))) begin
            state      <= StTitle;
            game_state <= 2'd0;
            game_over  <= 1'b0;
            frame_cnt  <= 9'd0;
          end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 9'd1;
          end
        end
        default: begin
          state      <= StTitle;
          game_state <= 2'd0;
          game_over  <= 1'b0;
          frame_cnt  <= 9'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rally_sequencer.sv
// Scoreboard bench for rally_sequencer: stimulus pushes expected output snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps

module tb_rally_sequencer;

  logic        clk;
  logic        reset_n;
  logic        frame_tick;
  logic        start_btn;
  logic        mode_btn;
  logic [11:0] ball_pos_x;
  logic [11:0] ball_pos_y;
  logic [1:0]  game_state;
  logic        game_mode;
  logic [4:0]  npc_score;
  logic [4:0]  player_score;
  logic        serve_side;
  logic        last_point;
  logic        game_over;
  logic        winner;

  rally_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_tick   (frame_tick),
    .start_btn    (start_btn),
    .mode_btn     (mode_btn),
    .ball_pos_x   (ball_pos_x),
    .ball_pos_y   (ball_pos_y),
    .game_state   (game_state),
    .game_mode    (game_mode),
    .npc_score    (npc_score),
    .player_score (player_score),
    .serve_side   (serve_side),
    .last_point   (last_point),
    .game_over    (game_over),
    .winner       (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [16:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Expected output state, updated by hand alongside the stimulus.
  logic [1:0] e_gs;
  logic       e_mode;
  logic [4:0] e_npc;
  logic [4:0] e_ply;
  logic       e_serve;
  logic       e_last;
  logic       e_over;
  logic       e_win;

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t       e;
      logic [16:0] act;
      e   = sb.pop_front();
      act = {game_state, game_mode, npc_score, player_score, serve_side, last_point,
             game_over, winner};
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s: got gs=%0d mode=%0d npc=%0d ply=%0d serve=%0d last=%0d over=%0d win=%0d, want gs=%0d mode=%0d npc=%0d ply=%0d serve=%0d last=%0d over=%0d win=%0d",
                 e.name, act[16:15], act[14], act[13:9], act[8:4], act[3], act[2], act[1],
                 act[0], e.v[16:15], e.v[14], e.v[13:9], e.v[8:4], e.v[3], e.v[2], e.v[1],
                 e.v[0]);
      end
    end
  end

  task automatic expect_out(input string name);
    exp_t e;
    e.name = name;
    e.v    = {e_gs, e_mode, e_npc, e_ply, e_serve, e_last, e_over, e_win};
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_tick();
      cycle();
    end
  endtask

  task automatic set_reset_exp();
    e_gs = 2'd0; e_mode = 1'b0; e_npc = 5'd0; e_ply = 5'd0;
    e_serve = 1'b1; e_last = 1'b0; e_over = 1'b0; e_win = 1'b0;
  endtask

  // One full point from PLAY: land, freeze, then either serve again or end the game.
  task automatic play_point(input bit pl);
    logic [4:0] sc;
    logic [4:0] op;
    bit         w;
    if (pl) begin
      ball_pos_x = 12'd40;  ball_pos_y = 12'd200;
    end else begin
      ball_pos_x = 12'd200; ball_pos_y = 12'd188;
    end
    pulse_tick();
    ball_pos_x = 12'd100; ball_pos_y = 12'd0;
    if (pl) begin
      e_ply = (e_ply == 5'd31) ? 5'd31 : e_ply + 5'd1;
    end else begin
      e_npc = (e_npc == 5'd31) ? 5'd31 : e_npc + 5'd1;
    end
    e_last = pl; e_serve = pl; e_gs = 2'd3;
    expect_out(pl ? "land_player" : "land_npc");
    ticks(89);
    expect_out("point_hold");
    ticks(1);
    sc = pl ? e_ply : e_npc;
    op = pl ? e_npc : e_ply;
`ifdef RALLY_DEUCE_EN
    w = (sc == 5'd31) || ((sc >= 5'd15) && (sc >= op + 5'd2));
`else
    w = (sc == 5'd15);
`endif
    if (w) begin
      e_gs = 2'd0; e_over = 1'b1; e_win = pl;
      expect_out("point_to_over");
    end else begin
      e_gs = 2'd1;
      expect_out("point_to_serve");
      ticks(60);
      e_gs = 2'd2;
      expect_out("serve_to_play");
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, want finish before 1ms");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; start_btn = 1'b0; mode_btn = 1'b0;
    ball_pos_x = 12'd100; ball_pos_y = 12'd0;
    set_reset_exp();
    #23;
    reset_n = 1'b1;
    cycle();
    expect_out("reset_values");

    // Mode toggles on each rise while in TITLE.
    mode_btn = 1'b1; cycle(); e_mode = 1'b1; expect_out("mode_rise1");
    cycle(); expect_out("mode_held");
    mode_btn = 1'b0; cycle();
    mode_btn = 1'b1; cycle(); e_mode = 1'b0; expect_out("mode_rise2");
    mode_btn = 1'b0; cycle();

    // Start with a coincident tick: the tick must not be counted.
    start_btn = 1'b1; frame_tick = 1'b1; cycle();
    start_btn = 1'b0; frame_tick = 1'b0;
    e_gs = 2'd1; expect_out("start_to_serve");
    ticks(59); expect_out("serve_59");
    ticks(1); e_gs = 2'd2; expect_out("serve_60_play");

    // Bottom edge at 219: no landing.
    ball_pos_x = 12'd200; ball_pos_y = 12'd187;
    pulse_tick(); expect_out("no_land_219");

    // Landed ball without frame_tick is ignored.
    ball_pos_y = 12'd188;
    repeat (1000) cycle();
    expect_out("landed_no_tick");
    ball_pos_x = 12'd100; ball_pos_y = 12'd0;

    // Alternate points up to 14-14.
    for (int i = 0; i < 14; i++) begin
      play_point(1'b1);
      play_point(1'b0);
    end
    play_point(1'b0);
`ifdef RALLY_DEUCE_EN
    play_point(1'b1);
    play_point(1'b0);
    play_point(1'b0);
`endif

    // Start rise in OVER returns to TITLE with scores held.
    start_btn = 1'b1; cycle(); start_btn = 1'b0;
    e_gs = 2'd0; e_over = 1'b0; expect_out("over_start_exit");
    cycle();
    start_btn = 1'b1; cycle(); start_btn = 1'b0;
    e_gs = 2'd1; e_npc = 5'd0; e_ply = 5'd0; e_serve = 1'b1;
    expect_out("restart_clears");
    ticks(60); e_gs = 2'd2; expect_out("restart_play");

    // Short asynchronous reset pulse; checked before the next rising edge.
    reset_n = 1'b0; #3; reset_n = 1'b1;
    set_reset_exp();
    expect_out("async_reset");
    cycle(); expect_out("after_reset");

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
